// File: rtl/alu_pipe_stage.sv
// Single-stage ALU with a valid/ready pipeline register and one skid entry.
// The result and flags are registered, so the stage breaks the timing path on both sides.
module alu_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_VALID,
  output logic             o_READY,
  input  logic [2:0]       i_OP,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_C,
  output logic             o_Z,
  output logic             o_V,
  output logic [1:0]       o_STATE
);

  // Handshake: a beat moves on a rising edge only when the sender's valid
  // and the receiver's ready are both high. Once valid is raised, the
  // payload holds until that edge. o_VALID and o_READY come from the state
  // and reset only, so the stage adds no combinational path between the
  // two sides.

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_SLTU  = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int RW  = WIDTH + 3;
  localparam int MSB = WIDTH - 1;

  logic [1:0]       state;
  logic [RW-1:0]    main_q;
  logic [RW-1:0]    skid_q;
  logic [RW-1:0]    res;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] y;
  logic             c;
  logic             z;
  logic             v;
  logic             in_xfer;
  logic             out_xfer;

  // The extra top bit is the carry for ADD. For SUB it is the borrow.
  assign add_full = {1'b0, i_A} + {1'b0, i_B};
  assign sub_full = {1'b0, i_A} - {1'b0, i_B};

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (i_OP)
      OP_ADD: begin
        y = add_full[WIDTH-1:0];
        c = add_full[WIDTH];
        v = (i_A[MSB] == i_B[MSB]) && (add_full[MSB] != i_A[MSB]);
      end
      OP_SUB: begin
        y = sub_full[WIDTH-1:0];
        c = sub_full[WIDTH];
        v = (i_A[MSB] != i_B[MSB]) && (sub_full[MSB] != i_A[MSB]);
      end
      OP_AND:   y = i_A & i_B;
      OP_OR:    y = i_A | i_B;
      OP_XOR:   y = i_A ^ i_B;
      OP_SLT:   y[0] = $signed(i_A) < $signed(i_B);
      OP_SLTU:  y[0] = i_A < i_B;
      OP_PASSB: y = i_B;
      default:  y = '0;
    endcase
    z   = (y == '0);
    res = {y, c, z, v};
  end

  assign o_READY  = ~i_RST & (state != ST_FULL);
  assign o_VALID  = ~i_RST & (state != ST_EMPTY);
  assign in_xfer  = i_VALID & o_READY;
  assign out_xfer = o_VALID & i_READY;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q <= res;
            state  <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_xfer && out_xfer) begin
            main_q <= res;
          end else if (in_xfer) begin
            skid_q <= res;
            state  <= ST_FULL;
          end else if (out_xfer) begin
            state  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Input is blocked here, so the skid entry is the next result out.
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= ST_HALF;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign {o_Y, o_C, o_Z, o_V} = main_q;
  assign o_STATE = state;

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Bench for alu_pipe_stage: directed scenarios with literal expectations,
// then randomized traffic checked against a queue-based reference model.
module tb_alu_pipe_stage;

  localparam int W  = 4;
  localparam int RW = W + 3;
  localparam int M  = 2 ** W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         drv_valid = 1'b0;
  logic [2:0]   drv_op = '0;
  logic [W-1:0] drv_a = '0;
  logic [W-1:0] drv_b = '0;
  logic         dn_ready = 1'b0;
  logic         up_ready;
  logic         out_valid;
  logic [W-1:0] y;
  logic         c;
  logic         z;
  logic         v;
  logic [1:0]   st;

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];

  alu_pipe_stage #(.WIDTH(W)) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_VALID (drv_valid),
    .o_READY (up_ready),
    .i_OP    (drv_op),
    .i_A     (drv_a),
    .i_B     (drv_b),
    .o_VALID (out_valid),
    .i_READY (dn_ready),
    .o_Y     (y),
    .o_C     (c),
    .o_Z     (z),
    .o_V     (v),
    .o_STATE (st)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference ALU built from plain integer arithmetic.
  function automatic logic [RW-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = (ua >= M / 2) ? ua - M : ua;
    int sb = (ub >= M / 2) ? ub - M : ub;
    int yv = 0;
    int s  = 0;
    bit cc = 1'b0;
    bit vv = 1'b0;
    bit zz;
    case (op)
      3'd0: begin yv = (ua + ub) % M; cc = (ua + ub) >= M; s = sa + sb; vv = (s < -(M / 2)) || (s >= M / 2); end
      3'd1: begin yv = (ua - ub + M) % M; cc = ua < ub; s = sa - sb; vv = (s < -(M / 2)) || (s >= M / 2); end
      3'd2: yv = ua & ub;
      3'd3: yv = ua | ub;
      3'd4: yv = ua ^ ub;
      3'd5: yv = (sa < sb) ? 1 : 0;
      3'd6: yv = (ua < ub) ? 1 : 0;
      default: yv = ub;
    endcase
    zz = (yv == 0);
    return {yv[W-1:0], cc, zz, vv};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    drv_valid = 1'b1;
    drv_op    = op;
    drv_a     = a;
    drv_b     = b;
  endtask

  // Operand lines carry random junk while valid is low.
  task automatic idle();
    drv_valid = 1'b0;
    drv_op    = 3'($urandom_range(0, 7));
    drv_a     = W'($urandom_range(0, M - 1));
    drv_b     = W'($urandom_range(0, M - 1));
  endtask

  // Model: a FIFO of at most two pending results.
  always @(posedge clk or posedge rst) begin : model
    bit pop;
    bit push;
    if (rst) begin
      exp_q.delete();
    end else begin
      pop  = (exp_q.size() > 0) && dn_ready;
      push = drv_valid && (exp_q.size() < 2);
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(ref_alu(drv_op, drv_a, drv_b));
    end
  end

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ready", int'(up_ready), 0);
      chk("rst_result", int'({y, c, z, v}), 0);
    end else begin
      chk("ready", int'(up_ready), int'(exp_q.size() < 2));
      chk("valid", int'(out_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("result", int'({y, c, z, v}), int'(exp_q[0]));
    end
  end

  initial begin
    // Pin the model with hand-computed values.
    chk("model_add", int'(ref_alu(3'd0, 4'b0111, 4'b0001)), int'(7'b1000_001));
    chk("model_sub", int'(ref_alu(3'd1, 4'b0011, 4'b0101)), int'(7'b1110_100));
    chk("model_slt", int'(ref_alu(3'd5, 4'b1111, 4'b0001)), int'(7'b0001_000));

    idle();
    repeat (3) step();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_ready", int'(up_ready), 0);
    chk("reset_y", int'(y), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", int'(up_ready), 1);

    // ADD overflow, one cycle latency
    dn_ready = 1'b1;
    drive(3'd0, 4'b0111, 4'b0001);
    step();
    idle();
    chk("add_valid", int'(out_valid), 1);
    chk("add_y", int'(y), 4'b1000);
    chk("add_cvz", int'({c, v, z}), 3'b010);
    step();
    chk("add_valid_drop", int'(out_valid), 0);

    // SUB with borrow, then with overflow
    drive(3'd1, 4'b0011, 4'b0101);
    step();
    drive(3'd1, 4'b1000, 4'b0001);
    chk("sub1_y", int'(y), 4'b1110);
    chk("sub1_cvz", int'({c, v, z}), 3'b100);
    step();
    idle();
    chk("sub2_y", int'(y), 4'b0111);
    chk("sub2_cv", int'({c, v}), 2'b01);
    step();

    // Backpressure into the skid register
    dn_ready = 1'b0;
    drive(3'd0, 4'b0001, 4'b0001);
    step();
    drive(3'd4, 4'b0101, 4'b0101);
    step();
    chk("bp_full_ready", int'(up_ready), 0);
    drive(3'd3, 4'b0011, 4'b0000);
    step();
    chk("bp_held_ready", int'(up_ready), 0);
    chk("bp_stable_y", int'(y), 4'b0010);
    dn_ready = 1'b1;
    step();
    chk("bp_ready_back", int'(up_ready), 1);
    chk("bp_second_y", int'(y), 4'b0000);
    chk("bp_second_z", int'(z), 1);
    step();
    idle();
    chk("bp_third_y", int'(y), 4'b0011);
    step();
    chk("bp_drained", int'(out_valid), 0);

    // Full-rate stream
    for (int i = 0; i < 8; i++) begin
      drive(3'($urandom_range(0, 7)), W'($urandom_range(0, M - 1)), W'($urandom_range(0, M - 1)));
      step();
      chk("stream_ready", int'(up_ready), 1);
      chk("stream_valid", int'(out_valid), 1);
    end
    idle();
    step();

    // Compare opcodes and PASSB on A=1111 B=0001
    drive(3'd5, 4'b1111, 4'b0001);
    step();
    drive(3'd6, 4'b1111, 4'b0001);
    chk("slt_yz", int'({y, z}), 5'b0001_0);
    step();
    drive(3'd7, 4'b1111, 4'b0001);
    chk("sltu_yz", int'({y, z}), 5'b0000_1);
    step();
    idle();
    chk("passb_y", int'(y), 4'b0001);
    step();

    // Reset while FULL, asserted between edges
    dn_ready = 1'b0;
    drive(3'd0, 4'b0010, 4'b0010);
    step();
    drive(3'd2, 4'b0110, 4'b0011);
    step();
    idle();
    chk("pre_rst_full", int'(up_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ready", int'(up_ready), 0);
    step();
    rst = 1'b0;
    dn_ready = 1'b1;
    drive(3'd1, 4'b0101, 4'b0010);
    step();
    idle();
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_y", int'(y), 4'b0011);
    step();

    // Randomized traffic with varying backpressure
    for (int ph = 0; ph < 4; ph++) begin
      repeat (100) begin
        if ($urandom_range(0, 3) != 0)
          drive(3'($urandom_range(0, 7)), W'($urandom_range(0, M - 1)), W'($urandom_range(0, M - 1)));
        else
          idle();
        dn_ready = ($urandom_range(0, 3) > ph) ? 1'b1 : 1'b0;
        step();
      end
    end
    idle();
    dn_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe_stage.md
ALU_PIPE_STAGE -- requirements
Module: alu_pipe_stage

Interface
REQ-001 The block SHALL have parameter: WIDTH, default 4, operand and result width in bits (minimum 2).
REQ-002 The block SHALL have port: i_CLK  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: i_RST  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port: i_VALID  input  1  upstream operands valid.
REQ-005 The block SHALL have port: o_READY  output  1  block can accept operands.
REQ-006 The block SHALL have port: i_OP  input  3  opcode.
REQ-007 The block SHALL have ports: i_A, i_B  input  WIDTH  operands, two's complement.
REQ-008 The block SHALL have port: o_VALID  output  1  result valid to downstream.
REQ-009 The block SHALL have port: i_READY  input  1  downstream accepts result.
REQ-010 The block SHALL have port: o_Y  output  WIDTH  result.
REQ-011 The block SHALL have ports: o_C, o_Z, o_V  output  1 each  carry/borrow, zero, signed overflow flags.

Function
REQ-012 Input transfer SHALL occur on a rising edge with i_VALID=1 and o_READY=1; output transfer SHALL occur on a rising edge with o_VALID=1 and i_READY=1.
REQ-013 Result and flags SHALL be computed combinationally from i_OP/i_A/i_B and captured on input transfer; latency SHALL be 1 cycle (o_VALID high the cycle after acceptance).
REQ-014 Opcodes SHALL be: 000 ADD Y=A+B; 001 SUB Y=A-B; 010 AND; 011 OR; 100 XOR; 101 SLT Y=1 if signed A<B else 0; 110 SLTU Y=1 if unsigned A<B else 0; 111 PASSB Y=B.
REQ-015 Arithmetic SHALL wrap modulo 2^WIDTH; ADD: C=carry out of MSB, V=signed overflow; SUB: C=1 iff unsigned A<B (borrow), V=signed overflow; all other opcodes: C=0, V=0.
REQ-016 Z SHALL be 1 iff Y equals zero, for every opcode.
REQ-017 Storage SHALL be a main output register plus one skid register; FSM states EMPTY, HALF, FULL.
REQ-018 Outputs per state: EMPTY o_VALID=0 o_READY=1; HALF o_VALID=1 o_READY=1; FULL o_VALID=1 o_READY=0; both decoded only from state and i_RST, with no combinational path from i_READY or i_VALID to any output.
REQ-019 EMPTY: input transfer -> HALF, main loaded.
REQ-020 HALF: input and output transfer -> HALF, main reloaded with new result; input only -> FULL, skid loaded; output only -> EMPTY; neither -> HALF, no change.
REQ-021 FULL: output transfer -> HALF, main loaded from skid; otherwise hold; no input accepted.
REQ-022 o_Y and flags SHALL remain stable while o_VALID=1 and i_READY=0.
REQ-023 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-024 With i_VALID and i_READY held high, throughput SHALL be one result per cycle with no bubbles.
REQ-025 i_OP/i_A/i_B SHALL be ignored when i_VALID=0; i_READY SHALL be ignored when o_VALID=0.

Reset
REQ-026 While i_RST=1: state EMPTY, o_VALID=0, o_READY=0, o_Y=0, o_C=o_Z=o_V=0, skid cleared, effective immediately without a clock edge.
REQ-027 o_READY SHALL rise to 1 combinationally when i_RST deasserts; first input transfer is possible on the first rising edge after deassertion.
REQ-028 Reset mid-operation SHALL discard main and skid contents; no stale result SHALL appear afterwards.

Verification (WIDTH=4)
REQ-029 Reset, then ADD A=0111 B=0001 for one cycle, i_READY=1 -> next cycle o_VALID=1, o_Y=1000, C=0, V=1, Z=0; the cycle after, o_VALID=0.
REQ-030 SUB A=0011 B=0101 -> o_Y=1110, C=1, V=0, Z=0; SUB A=1000 B=0001 -> o_Y=0111, C=0, V=1.
REQ-031 i_READY=0, send ADD 0001+0001 then XOR 0101^0101 -> o_READY=0 after second; third operand held off; raise i_READY -> o_Y=0010 then o_Y=0000 with Z=1, in order, and o_READY=1 the cycle after the first output transfer.
REQ-032 i_VALID=i_READY=1 for 8 cycles with varying ops -> 8 consecutive correct results, state never FULL, o_READY constantly 1.
REQ-033 Fill to FULL, assert i_RST between edges -> o_VALID=0 and o_READY=0 immediately; after deassertion, the first output equals the first new operation.
REQ-034 A=1111 B=0001: SLT -> o_Y=0001, Z=0; SLTU -> o_Y=0000, Z=1; PASSB -> o_Y=0001.
